// File: rtl/bcd_counter_pkg.sv
// Shared BCD digit type, limit constant and digit clamp
// for the event counter slice.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t bcd_clamp(bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of a ripple add/subtract chain.
// cout is the decimal carry (add) or borrow (sub).
module bcd_digit_addsub
  import bcd_counter_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] a5;
  logic [4:0] b5;
  logic [4:0] raw;

  always_comb begin
    a5   = {1'b0, bcd_clamp(a)};
    b5   = {1'b0, bcd_clamp(b)};
    raw  = '0;
    sum  = '0;
    cout = 1'b0;
    if (sub) begin
      // range -10..9, so bit 4 is the sign
      raw  = a5 - b5 - {4'd0, cin};
      cout = raw[4];
      sum  = cout ? raw[3:0] + 4'd10 : raw[3:0];
    end else begin
      raw  = a5 + b5 + {4'd0, cin};
      cout = (raw > 5'd9);
      sum  = cout ? raw[3:0] + 4'd6 : raw[3:0];
    end
  end

endmodule

// File: rtl/bcd_event_counter.sv
// N-digit BCD score/timer counter stepped by frame ticks,
// with BCD add, load, clear and wrap or saturate limits.
module bcd_event_counter
  import bcd_counter_pkg::*;
#(
  parameter int N_DIGITS        = 4,
  parameter int FRAMES_PER_STEP = 1,
  parameter bit SATURATE        = 1'b0
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic                        enable,
  input  logic                        count_down,
  input  logic                        clear,
  input  logic                        load,
  input  logic [N_DIGITS*4-1:0]       load_value,
  input  logic                        add_en,
  input  logic [N_DIGITS*4-1:0]       add_value,
  output logic [0:N_DIGITS-1][0:3]    num,
  output logic                        at_limit,
  output logic                        terminal
);

  localparam logic [7:0] PS_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam bcd_digit_t [N_DIGITS-1:0] ALL9 = {N_DIGITS{BCD_MAX}};

  logic [7:0] presc_q, presc_d;
  logic       pend_q, pend_d;
  logic       term_q, term_d;

  bcd_digit_t [N_DIGITS-1:0] num_q, num_d;
  bcd_digit_t [N_DIGITS-1:0] opb, res;

  logic tick, step, cout, sat_hit;

  assign tick = startOfFrame & enable;
  assign step = tick & (presc_q == PS_LAST);

  // One chain serves both the add (b=addend) and the +/-1 step (b=0, cin=1)
  assign opb = add_en ? add_value : '0;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    logic ci;
    logic co;
    if (i == 0) begin : g_lsd
      assign ci = ~add_en;
    end else begin : g_up
      assign ci = g_dig[i-1].co;
    end
    bcd_digit_addsub u_dig (
      .a   (num_q[i]),
      .b   (opb[i]),
      .cin (ci),
      .sub (~add_en & count_down),
      .sum (res[i]),
      .cout(co)
    );
  end

  assign cout    = g_dig[N_DIGITS-1].co;
  assign sat_hit = cout & SATURATE;

  always_comb begin
    presc_d = presc_q;
    pend_d  = pend_q;
    num_d   = num_q;
    term_d  = 1'b0;
    if (tick) begin
      presc_d = step ? 8'd0 : presc_q + 8'd1;
    end
    if (clear) begin
      num_d   = '0;
      presc_d = '0;
      pend_d  = 1'b0;
    end else if (load) begin
      num_d   = load_value;
      presc_d = '0;
      pend_d  = 1'b0;
    end else if (add_en) begin
      if (step) begin
        pend_d = 1'b1;
      end
      term_d = cout;
      num_d  = sat_hit ? ALL9 : res;
    end else if (step | pend_q) begin
      pend_d = 1'b0;
      term_d = cout;
      if (!sat_hit) begin
        num_d = res;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      presc_q <= '0;
      pend_q  <= 1'b0;
      term_q  <= 1'b0;
      num_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pend_q  <= pend_d;
      term_q  <= term_d;
      num_q   <= num_d;
    end
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_out
    assign num[i] = num_q[i];
  end

  assign at_limit = count_down ? (num_q == '0) : (num_q == ALL9);
  assign terminal = term_q;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Bench: two counter variants (wrap/FPS=1, saturate/FPS=3)
// against an integer-arithmetic reference model.
module tb_bcd_event_counter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        enable;
  logic        count_down;
  logic        clear;
  logic        load;
  logic [15:0] load_value;
  logic        add_en;
  logic [15:0] add_value;

  logic [0:3][0:3] numA, numB;
  logic            at_limitA, at_limitB;
  logic            terminalA, terminalB;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  always #5 clk = ~clk;

  bcd_event_counter #(
    .N_DIGITS(4), .FRAMES_PER_STEP(1), .SATURATE(1'b0)
  ) uA (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .enable(enable), .count_down(count_down), .clear(clear),
    .load(load), .load_value(load_value), .add_en(add_en),
    .add_value(add_value), .num(numA), .at_limit(at_limitA),
    .terminal(terminalA)
  );

  bcd_event_counter #(
    .N_DIGITS(4), .FRAMES_PER_STEP(3), .SATURATE(1'b1)
  ) uB (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .enable(enable), .count_down(count_down), .clear(clear),
    .load(load), .load_value(load_value), .add_en(add_en),
    .add_value(add_value), .num(numB), .at_limit(at_limitB),
    .terminal(terminalB)
  );

  typedef struct packed {
    logic [15:0] raw;
    logic [7:0]  presc;
    logic        pend;
    logic        term;
  } mstate_t;

  mstate_t mA = '0;
  mstate_t mB = '0;

  function automatic int to_int(logic [15:0] r);
    int v = 0;
    for (int i = 3; i >= 0; i--) begin
      int d = int'(r[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] from_int(int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] flat(logic [0:3][0:3] n);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = n[i];
    return r;
  endfunction

  function automatic logic lim(logic [15:0] raw);
    return count_down ? (raw == 16'h0000) : (raw == 16'h9999);
  endfunction

  function automatic mstate_t mnext(mstate_t s, int fps, bit sat);
    mstate_t n;
    bit stp;
    int v, r;
    n = s;
    n.term = 1'b0;
    stp = 1'b0;
    v = to_int(s.raw);
    if (startOfFrame && enable) begin
      if (int'(s.presc) == fps - 1) begin
        n.presc = '0;
        stp = 1'b1;
      end else begin
        n.presc = s.presc + 8'd1;
      end
    end
    if (clear) begin
      n.raw = '0; n.presc = '0; n.pend = 1'b0;
    end else if (load) begin
      n.raw = load_value; n.presc = '0; n.pend = 1'b0;
    end else if (add_en) begin
      r = v + to_int(add_value);
      if (r > 9999) begin
        n.term = 1'b1;
        r = sat ? 9999 : r - 10000;
      end
      n.raw = from_int(r);
      if (stp) n.pend = 1'b1;
    end else if (stp || s.pend) begin
      n.pend = 1'b0;
      r = count_down ? v - 1 : v + 1;
      if (r > 9999 || r < 0) begin
        n.term = 1'b1;
        if (!sat) n.raw = from_int(r < 0 ? 9999 : 0);
      end else begin
        n.raw = from_int(r);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mA <= '0;
      mB <= '0;
    end else begin
      mA <= mnext(mA, 1, 1'b0);
      mB <= mnext(mB, 3, 1'b1);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("A.num",      flat(numA), mA.raw);
      chk("A.at_limit", at_limitA,  lim(mA.raw));
      chk("A.terminal", terminalA,  mA.term);
      chk("B.num",      flat(numB), mB.raw);
      chk("B.at_limit", at_limitB,  lim(mB.raw));
      chk("B.terminal", terminalB,  mB.term);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      cyc();
      startOfFrame = 1'b0;
      cyc();
    end
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 4))
      0: return from_int(9990 + int'($urandom_range(0, 9)));
      1: return from_int(int'($urandom_range(0, 9)));
      2: return 16'($urandom);
      default: return from_int(int'($urandom_range(0, 9999)));
    endcase
  endfunction

  initial begin
    bit prev_sof;
    int r;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    enable       = 1'b1;
    count_down   = 1'b0;
    clear        = 1'b0;
    load         = 1'b0;
    load_value   = '0;
    add_en       = 1'b0;
    add_value    = '0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    chk_on = 1'b1;
    chk("reset A.num", flat(numA), 16'h0000);
    chk("reset A.terminal", terminalA, 1'b0);
    chk("reset B.num", flat(numB), 16'h0000);

    // count up to the top, then wrap
    tick(9999);
    chk("t1 A.num 9999", flat(numA), 16'h9999);
    chk("t1 A.at_limit", at_limitA, 1'b1);
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
    chk("t1 A.wrap num", flat(numA), 16'h0000);
    chk("t1 A.wrap terminal", terminalA, 1'b1);
    cyc();
    chk("t1 A.terminal width", terminalA, 1'b0);

    // prescaler with enable gating
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    tick(7);
    chk("t2 B.num 7 ticks", flat(numB), 16'h0002);
    enable = 1'b0;
    tick(5);
    chk("t2 B.num disabled", flat(numB), 16'h0002);
    enable = 1'b1;
    tick(2);
    chk("t2 B.num 9 ticks", flat(numB), 16'h0003);
    chk("t2 A.num 9 ticks", flat(numA), 16'h0009);

    // add coinciding with a step
    startOfFrame = 1'b1;
    add_en = 1'b1;
    add_value = 16'h0041;
    cyc();
    startOfFrame = 1'b0;
    add_en = 1'b0;
    chk("t4 A.add", flat(numA), 16'h0050);
    chk("t4 B.add", flat(numB), 16'h0044);
    cyc();
    chk("t4 A.pending", flat(numA), 16'h0051);
    startOfFrame = 1'b1;
    add_en = 1'b1;
    clear = 1'b1;
    cyc();
    startOfFrame = 1'b0;
    add_en = 1'b0;
    clear = 1'b0;
    chk("t4 A.clear wins", flat(numA), 16'h0000);
    cyc();
    chk("t4 A.no pending", flat(numA), 16'h0000);

    // saturating count down
    count_down = 1'b1;
    load = 1'b1;
    load_value = 16'h0002;
    cyc();
    load = 1'b0;
    tick(3);
    chk("t3 B.num 1", flat(numB), 16'h0001);
    tick(3);
    chk("t3 B.num 0", flat(numB), 16'h0000);
    tick(2);
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
    chk("t3 B.hold", flat(numB), 16'h0000);
    chk("t3 B.terminal", terminalB, 1'b1);
    chk("t3 B.at_limit", at_limitB, 1'b1);
    cyc();

    // add overflow
    count_down = 1'b0;
    load = 1'b1;
    load_value = 16'h9990;
    cyc();
    load = 1'b0;
    add_en = 1'b1;
    add_value = 16'h0015;
    cyc();
    add_en = 1'b0;
    chk("t5 A.wrap add", flat(numA), 16'h0005);
    chk("t5 A.terminal", terminalA, 1'b1);
    chk("t5 B.sat add", flat(numB), 16'h9999);
    chk("t5 B.terminal", terminalB, 1'b1);
    cyc();

    // reset mid-count
    load = 1'b1;
    load_value = 16'h0437;
    cyc();
    load = 1'b0;
    tick(1);
    resetN = 1'b0;
    #1;
    chk("t6 A.num reset", flat(numA), 16'h0000);
    chk("t6 B.num reset", flat(numB), 16'h0000);
    chk("t6 B.terminal reset", terminalB, 1'b0);
    @(posedge clk);
    #1 resetN = 1'b1;
    tick(2);
    chk("t6 B.no early step", flat(numB), 16'h0000);
    tick(1);
    chk("t6 B.first step", flat(numB), 16'h0001);

    // randomized traffic
    prev_sof = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      r = int'($urandom_range(0, 99));
      clear = (r == 0);
      load = (r >= 1 && r <= 3);
      add_en = (r >= 4 && r <= 14);
      load_value = pick_val();
      add_value = pick_val();
      startOfFrame = !prev_sof && ($urandom_range(0, 1) == 1);
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 63) == 0) count_down = ~count_down;
      cyc();
      prev_sof = startOfFrame;
    end
    startOfFrame = 1'b0;
    clear = 1'b0;
    load = 1'b0;
    add_en = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
